pwm_seq_ctl: RTL and testbench
==============================

Name: pwm_seq_ctl

Overview:
Job sequencer for the point-wise modular multiplication (PWM) datapath behind the AXI-Stream port.
- Operand A stream (PRM_WORDS 64-bit words, two 32-bit coefficients each) is written into a local coefficient RAM.
- Operand B stream is paired word-by-word with A read back from RAM and issued to the fixed-latency dual-lane modular multiplier.
- Results are buffered in an output FIFO and streamed out on M-AXIS with TLAST; backpressure is handled by credits.
- Sits between the AXI-Lite control registers (start, Q select) and the RAM, multiplier and stream ports.

Parameters:
PRM_DAXI, 64, stream/RAM/multiplier word width (2 coefficients of PRM_DAXI/2 bits)
PRM_ADDR, 11, RAM word-address width
PRM_WORDS, 2048, words per operand (4096 coefficients)
PRM_MUL_LAT, 6, multiplier latency, oMUL_VALID to iMUL_VALID, fixed
PRM_OFIFO_DEPTH, 16, output FIFO entries (power of 2, >= 2)

Ports:
iSYS_CLK  in  1  system clock
iSYS_RST  in  1  synchronous active-low reset
iCTL_START  in  1  one-cycle start pulse; ignored unless IDLE
iCTL_Q  in  2  modulus select, latched on accepted start
oCTL_BUSY  out  1  high in any state except IDLE
oCTL_DONE  out  1  one-cycle pulse after the last result handshake
oCTL_ERR  out  1  sticky TLAST-framing error; cleared on accepted start
iS_AXIS_TVALID  in  1  input stream valid
oS_AXIS_TREADY  out  1  input stream ready
iS_AXIS_TDATA  in  PRM_DAXI  input word
iS_AXIS_TLAST  in  1  input last
oRAM_WE  out  1  RAM write enable
oRAM_RE  out  1  RAM read enable
oRAM_ADDR  out  PRM_ADDR  RAM word address
oRAM_WDATA  out  PRM_DAXI  RAM write data
iRAM_RDATA  in  PRM_DAXI  RAM read data, valid 1 cycle after oRAM_RE
oMUL_VALID  out  1  multiplier issue strobe
oMUL_A  out  PRM_DAXI  operand A word
oMUL_B  out  PRM_DAXI  operand B word
oMUL_QSEL  out  2  latched iCTL_Q
iMUL_VALID  in  1  multiplier result strobe
iMUL_RES  in  PRM_DAXI  result word
oM_AXIS_TVALID  out  1  output valid
iM_AXIS_TREADY  in  1  output ready
oM_AXIS_TDATA  out  PRM_DAXI  result word
oM_AXIS_TLAST  out  1  high with result word PRM_WORDS-1

Behaviour:
- Reset (iSYS_RST=0 at a clock edge; also mid-job):
  - state=IDLE; all counters 0; credit=PRM_OFIFO_DEPTH; FIFO flushed.
  - Every output 0, including oCTL_ERR, oM_AXIS_TVALID, oS_AXIS_TREADY.
  - In-flight multiplier results arriving after reset are discarded.
- States:
  - IDLE: iCTL_START -> LOAD_A. Latch iCTL_Q into oMUL_QSEL, clear oCTL_ERR, clear word counter wc.
  - LOAD_A: oS_AXIS_TREADY=1. Each handshake: oRAM_WE=1, oRAM_ADDR=wc, oRAM_WDATA=TDATA (same cycle, combinational from handshake), then wc++. After word PRM_WORDS-1: wc=0 -> MUL.
  - MUL: oS_AXIS_TREADY = (credit != 0).
    - Handshake at cycle t: oRAM_RE=1, oRAM_ADDR=wc; B registered; credit--; wc++.
    - t+1: oMUL_VALID=1, oMUL_A=iRAM_RDATA, oMUL_B=registered B. Issue-to-result latency is therefore 1+PRM_MUL_LAT cycles.
    - After B word PRM_WORDS-1 -> DRAIN.
  - DRAIN: oS_AXIS_TREADY=0. Every iMUL_VALID pushes iMUL_RES into the FIFO.
    - After output count oc reaches PRM_WORDS -> IDLE, with oCTL_DONE=1 for exactly that transition cycle.
    - Outputs stream throughout MUL and DRAIN.
- Credit counter: pop (oM_AXIS_TVALID & iM_AXIS_TREADY) increments credit; accept decrements; same cycle = unchanged. Credit never exceeds PRM_OFIFO_DEPTH, so the FIFO can never overflow; iMUL_VALID is never stalled.
- Output FIFO: first-word-fall-through. oM_AXIS_TVALID = !empty. TDATA must stay stable while TVALID & !TREADY. Push and pop in the same cycle are both allowed. A push into an empty FIFO appears on TVALID the next cycle.
- oM_AXIS_TLAST = 1 when the head word is output index PRM_WORDS-1 (oc counts pops).
- Framing errors set oCTL_ERR; the word count stays authoritative and processing continues:
  - iS_AXIS_TLAST=1 on any word other than index PRM_WORDS-1 of either operand.
  - iS_AXIS_TLAST=0 on index PRM_WORDS-1.
- Gap between the A and B streams: in MUL, TREADY stays asserted and no state change occurs until B arrives.
- iCTL_START while busy: ignored; oCTL_Q latch unchanged.
- Counters are PRM_ADDR+1 bits wide so that wc==PRM_WORDS is representable; no wrap within a job.

Test Plan:
- Nominal job: A word k = {2k+1, 2k}, B word k = {3, 3}, iCTL_Q=2'b01, iM_AXIS_TREADY=1, multiplier model = lane-wise product mod 536903681 -> 2048 outputs, word k = {3(2k+1), 6k}; TLAST only on word 2047; oCTL_DONE one pulse; oCTL_ERR=0.
- Backpressure: as nominal, iM_AXIS_TREADY toggled 1-of-3 cycles -> oS_AXIS_TREADY drops whenever credit=0; outputs identical in content and order; no FIFO overflow; TDATA stable while stalled.
- Inter-stream gap: 50-cycle idle between A and B -> no spurious oMUL_VALID during the gap; results as nominal.
- Framing: TLAST on A word 100 and missing on B word 2047 -> oCTL_ERR=1 from word 100 until the next start; 2048 results still produced and DONE pulses.
- Start while busy: second iCTL_START with iCTL_Q=2'b10 during MUL -> ignored; oMUL_QSEL stays 2'b01.
- Reset mid-MUL at B word 500 -> the next cycle shows all outputs 0 and state IDLE; a subsequent full job passes as in nominal.

Source files
------------

// File: rtl/pwm_seq_ctl.sv
// Job sequencer for the point-wise modular multiplier: loads operand A into RAM, pairs it with
// streamed operand B, issues lane pairs to the multiplier and streams results out through a credited FIFO.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for start; outputs quiet
// LOAD_A   | accepting operand A words into the coefficient RAM
// MUL      | accepting operand B words, reading A back, issuing to the multiplier
// DRAIN    | waiting for the remaining results to leave the output stream
`timescale 1ns/1ps
module pwm_seq_ctl #(
    parameter int PRM_DAXI        = 64,
    parameter int PRM_ADDR        = 11,
    parameter int PRM_WORDS       = 2048,
    parameter int PRM_MUL_LAT     = 6,
    parameter int PRM_OFIFO_DEPTH = 16
) (
    input  logic                iSYS_CLK,
    input  logic                iSYS_RST,
    input  logic                iCTL_START,
    input  logic [1:0]          iCTL_Q,
    output logic                oCTL_BUSY,
    output logic                oCTL_DONE,
    output logic                oCTL_ERR,
    input  logic                iS_AXIS_TVALID,
    output logic                oS_AXIS_TREADY,
    input  logic [PRM_DAXI-1:0] iS_AXIS_TDATA,
    input  logic                iS_AXIS_TLAST,
    output logic                oRAM_WE,
    output logic                oRAM_RE,
    output logic [PRM_ADDR-1:0] oRAM_ADDR,
    output logic [PRM_DAXI-1:0] oRAM_WDATA,
    input  logic [PRM_DAXI-1:0] iRAM_RDATA,
    output logic                oMUL_VALID,
    output logic [PRM_DAXI-1:0] oMUL_A,
    output logic [PRM_DAXI-1:0] oMUL_B,
    output logic [1:0]          oMUL_QSEL,
    input  logic                iMUL_VALID,
    input  logic [PRM_DAXI-1:0] iMUL_RES,
    output logic                oM_AXIS_TVALID,
    input  logic                iM_AXIS_TREADY,
    output logic [PRM_DAXI-1:0] oM_AXIS_TDATA,
    output logic                oM_AXIS_TLAST
);
    localparam int PW = $clog2(PRM_OFIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int NW = PRM_ADDR + 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD_A = 2'd1;
    localparam logic [1:0] ST_MUL    = 2'd2;
    localparam logic [1:0] ST_DRAIN  = 2'd3;

    localparam logic [NW-1:0] LAST_IDX  = NW'(PRM_WORDS - 1);
    localparam logic [NW-1:0] WORDS_CNT = NW'(PRM_WORDS);
    localparam logic [CW-1:0] CRED_MAX  = CW'(PRM_OFIFO_DEPTH);

    logic [1:0]          state;
    logic [NW-1:0]       wc;
    logic [NW-1:0]       oc;
    logic [CW-1:0]       credit;
    logic [PRM_DAXI-1:0] b_reg;
    logic                issue_pend;
    logic [1:0]          qsel;
    logic                err;

    logic [PRM_DAXI-1:0] fifo_mem [PRM_OFIFO_DEPTH];
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic [CW-1:0]       fcount;

    logic s_ready, hs, hs_a, hs_b, start_ok, push, pop, f_valid, last_word, frame_bad, done;

    always_comb begin
        s_ready   = (state == ST_LOAD_A) || ((state == ST_MUL) && (credit != '0));
        hs        = iS_AXIS_TVALID && s_ready;
        hs_a      = hs && (state == ST_LOAD_A);
        hs_b      = hs && (state == ST_MUL);
        start_ok  = iCTL_START && (state == ST_IDLE);
        // Results are only meaningful inside a job; stragglers from an aborted job are dropped here.
        push      = iMUL_VALID && ((state == ST_MUL) || (state == ST_DRAIN));
        f_valid   = (fcount != '0);
        pop       = f_valid && iM_AXIS_TREADY;
        last_word = (wc == LAST_IDX);
        frame_bad = hs && (iS_AXIS_TLAST != last_word);
        done      = (state == ST_DRAIN) && (oc == WORDS_CNT);
    end

    always_ff @(posedge iSYS_CLK) begin
        if (!iSYS_RST) begin
            state      <= ST_IDLE;
            wc         <= '0;
            oc         <= '0;
            credit     <= CRED_MAX;
            b_reg      <= '0;
            issue_pend <= 1'b0;
            qsel       <= 2'b00;
            err        <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fcount     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        state <= ST_LOAD_A;
                        qsel  <= iCTL_Q;
                        wc    <= '0;
                    end
                end
                ST_LOAD_A: begin
                    if (hs_a) begin
                        if (last_word) begin
                            wc    <= '0;
                            state <= ST_MUL;
                        end else begin
                            wc <= wc + NW'(1);
                        end
                    end
                end
                ST_MUL: begin
                    if (hs_b) begin
                        wc <= wc + NW'(1);
                        if (last_word) state <= ST_DRAIN;
                    end
                end
                default: begin
                    if (done) state <= ST_IDLE;
                end
            endcase

            if (start_ok)       err <= 1'b0;
            else if (frame_bad) err <= 1'b1;

            if (start_ok) oc <= '0;
            else if (pop) oc <= oc + NW'(1);

            // Every issue reserves a FIFO slot, so an in-flight result always has somewhere to land.
            if (hs_b && !pop)      credit <= credit - CW'(1);
            else if (pop && !hs_b) credit <= credit + CW'(1);

            issue_pend <= hs_b;
            if (hs_b) b_reg <= iS_AXIS_TDATA;

            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      fcount <= fcount + CW'(1);
            else if (pop && !push) fcount <= fcount - CW'(1);
        end
    end

    always_ff @(posedge iSYS_CLK) begin
        if (push) fifo_mem[wr_ptr] <= iMUL_RES;
    end

    always_comb begin
        oCTL_BUSY      = (state != ST_IDLE);
        oCTL_DONE      = done;
        oCTL_ERR       = err;
        oS_AXIS_TREADY = s_ready;
        oRAM_WE        = hs_a;
        oRAM_RE        = hs_b;
        oRAM_ADDR      = hs ? wc[PRM_ADDR-1:0] : '0;
        oRAM_WDATA     = hs_a ? iS_AXIS_TDATA : '0;
        oMUL_VALID     = issue_pend;
        oMUL_A         = issue_pend ? iRAM_RDATA : '0;
        oMUL_B         = issue_pend ? b_reg : '0;
        oMUL_QSEL      = qsel;
        oM_AXIS_TVALID = f_valid;
        oM_AXIS_TDATA  = f_valid ? fifo_mem[rd_ptr] : '0;
        oM_AXIS_TLAST  = f_valid && (oc == LAST_IDX);
    end
endmodule

// File: tb/tb_pwm_seq_ctl.sv
// Bench for pwm_seq_ctl: RAM and multiplier models, a table of whole jobs with per-job expectations,
// and hand-written reset sequences.
`timescale 1ns/1ps
module tb_pwm_seq_ctl;
    localparam int WORDS = 2048;
    localparam int LAT   = 6;
    localparam int DEPTH = 16;
    localparam logic [63:0] QMOD = 64'd536903681;

    logic        clk;
    logic        rst;
    logic        ctl_start;
    logic [1:0]  ctl_q;
    logic        ctl_busy, ctl_done, ctl_err;
    logic        s_tvalid, s_tready, s_tlast;
    logic [63:0] s_tdata;
    logic        ram_we, ram_re;
    logic [10:0] ram_addr;
    logic [63:0] ram_wdata, ram_rdata;
    logic        mul_valid_o;
    logic [63:0] mul_a, mul_b;
    logic [1:0]  mul_qsel;
    logic        mul_valid_i;
    logic [63:0] mul_res;
    logic        m_tvalid, m_tready, m_tlast;
    logic [63:0] m_tdata;

    int checks = 0;
    int errors = 0;
    bit in_gap = 0;

    pwm_seq_ctl dut (
        .iSYS_CLK(clk), .iSYS_RST(rst),
        .iCTL_START(ctl_start), .iCTL_Q(ctl_q),
        .oCTL_BUSY(ctl_busy), .oCTL_DONE(ctl_done), .oCTL_ERR(ctl_err),
        .iS_AXIS_TVALID(s_tvalid), .oS_AXIS_TREADY(s_tready),
        .iS_AXIS_TDATA(s_tdata), .iS_AXIS_TLAST(s_tlast),
        .oRAM_WE(ram_we), .oRAM_RE(ram_re), .oRAM_ADDR(ram_addr),
        .oRAM_WDATA(ram_wdata), .iRAM_RDATA(ram_rdata),
        .oMUL_VALID(mul_valid_o), .oMUL_A(mul_a), .oMUL_B(mul_b), .oMUL_QSEL(mul_qsel),
        .iMUL_VALID(mul_valid_i), .iMUL_RES(mul_res),
        .oM_AXIS_TVALID(m_tvalid), .iM_AXIS_TREADY(m_tready),
        .oM_AXIS_TDATA(m_tdata), .oM_AXIS_TLAST(m_tlast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [63:0] ram [0:WORDS-1];
    logic [63:0] ram_q;
    always @(posedge clk) begin
        if (ram_we) ram[ram_addr] <= ram_wdata;
        if (ram_re) ram_q <= ram[ram_addr];
    end
    assign ram_rdata = ram_q;

    function automatic logic [63:0] mulmod(input logic [63:0] a, input logic [63:0] b);
        logic [63:0] hi, lo;
        hi = ({32'd0, a[63:32]} * {32'd0, b[63:32]}) % QMOD;
        lo = ({32'd0, a[31:0]} * {32'd0, b[31:0]}) % QMOD;
        return {hi[31:0], lo[31:0]};
    endfunction

    logic [LAT-1:0] mp_v = '0;
    logic [63:0]    mp_d [LAT];
    always @(posedge clk) begin
        mp_v     <= {mp_v[LAT-2:0], mul_valid_o};
        mp_d[0]  <= mulmod(mul_a, mul_b);
        for (int i = 1; i < LAT; i++) mp_d[i] <= mp_d[i-1];
    end
    assign mul_valid_i = mp_v[LAT-1];
    assign mul_res     = mp_d[LAT-1];

    function automatic logic [63:0] a_word(input int k);
        return {32'(2 * k + 1), 32'(2 * k)};
    endfunction
    function automatic logic [63:0] exp_out(input int k);
        return {32'(6 * k + 3), 32'(6 * k)};
    endfunction
    localparam logic [63:0] B_WORD = {32'd3, 32'd3};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Entered and left at posedge+1; handshake is judged from TREADY sampled at the negedge.
    task automatic send_word(input logic [63:0] data, input logic last);
        bit r;
        int n = 0;
        s_tvalid = 1'b1;
        s_tdata  = data;
        s_tlast  = last;
        forever begin
            @(negedge clk);
            r = s_tready;
            @(posedge clk);
            #1;
            if (r) break;
            n++;
            if (n > 2000) begin
                errors++;
                $display("FAIL s_handshake_timeout: no TREADY after %0d cycles", n);
                break;
            end
        end
    endtask

    typedef struct {
        logic [1:0] q;
        int         gap;
        bit         bp;
        int         bad_a;
        bit         drop_b_last;
        bit         busy_start;
        logic       exp_err;
        logic [1:0] exp_q;
    } job_t;

    task automatic run_job(input job_t j);
        int oc_tb = 0, done_cnt = 0, gap_bad = 0, outstanding = 0, cred_bad = 0, cyc = 0;
        bit stalled = 0;
        logic [63:0] held = '0;
        ctl_q = j.q;
        ctl_start = 1'b1;
        @(posedge clk); #1;
        ctl_start = 1'b0;
        chk("busy_after_start", ctl_busy, 1);
        chk("qsel_latched", mul_qsel, j.exp_q);
        chk("err_cleared_on_start", ctl_err, 0);
        fork
            begin
                for (int k = 0; k < WORDS; k++) begin
                    if (k == j.bad_a) chk("err_before_bad_tlast", ctl_err, 0);
                    send_word(a_word(k), (k == WORDS - 1) || (k == j.bad_a));
                    if (k == j.bad_a) chk("err_after_bad_tlast", ctl_err, 1);
                end
                if (j.gap > 0) begin
                    s_tvalid = 1'b0;
                    in_gap = 1'b1;
                    repeat (j.gap) begin @(posedge clk); #1; end
                    in_gap = 1'b0;
                end
                for (int k = 0; k < WORDS; k++) begin
                    if (j.busy_start && k == 10) begin
                        s_tvalid = 1'b0;
                        ctl_q = 2'b10;
                        ctl_start = 1'b1;
                        @(posedge clk); #1;
                        ctl_start = 1'b0;
                        chk("qsel_kept_on_busy_start", mul_qsel, j.exp_q);
                        chk("busy_kept_on_busy_start", ctl_busy, 1);
                    end
                    send_word(B_WORD, (k == WORDS - 1) && !j.drop_b_last);
                end
                s_tvalid = 1'b0;
                s_tlast = 1'b0;
            end
            begin
                while (cyc < 30000 && done_cnt == 0) begin
                    m_tready = j.bp ? (cyc % 3 == 0) : 1'b1;
                    @(negedge clk);
                    if (in_gap && mul_valid_o) gap_bad++;
                    if (stalled) chk("tdata_stable_while_stalled", m_tdata, held);
                    if (ram_re) outstanding++;
                    if (m_tvalid && m_tready) begin
                        chk("out_data", m_tdata, exp_out(oc_tb));
                        chk("out_tlast", m_tlast, (oc_tb == WORDS - 1));
                        oc_tb++;
                        outstanding--;
                    end
                    if (outstanding > DEPTH) cred_bad++;
                    stalled = m_tvalid && !m_tready;
                    held = m_tdata;
                    if (ctl_done) done_cnt++;
                    @(posedge clk); #1;
                    cyc++;
                end
                repeat (4) begin
                    @(negedge clk);
                    if (ctl_done) done_cnt++;
                    @(posedge clk); #1;
                end
            end
        join
        chk("out_count", oc_tb, WORDS);
        chk("done_pulses", done_cnt, 1);
        chk("err_at_end", ctl_err, j.exp_err);
        chk("qsel_at_end", mul_qsel, j.exp_q);
        chk("idle_at_end", ctl_busy, 0);
        chk("no_mul_valid_in_gap", gap_bad, 0);
        chk("credit_bound", cred_bad, 0);
    endtask

    task automatic check_all_zero(input string name);
        logic any;
        @(negedge clk);
        any = |{ctl_busy, ctl_done, ctl_err, s_tready, ram_we, ram_re, ram_addr, ram_wdata,
                mul_valid_o, mul_a, mul_b, mul_qsel, m_tvalid, m_tdata, m_tlast};
        chk(name, any, 0);
        chk({name, "_busy"}, ctl_busy, 0);
        chk({name, "_s_tready"}, s_tready, 0);
        @(posedge clk); #1;
    endtask

    job_t jobs [5];

    initial begin
        jobs[0] = '{q: 2'b01, gap: 0,  bp: 0, bad_a: -1,  drop_b_last: 0, busy_start: 0, exp_err: 0, exp_q: 2'b01};
        jobs[1] = '{q: 2'b01, gap: 0,  bp: 1, bad_a: -1,  drop_b_last: 0, busy_start: 0, exp_err: 0, exp_q: 2'b01};
        jobs[2] = '{q: 2'b01, gap: 50, bp: 0, bad_a: -1,  drop_b_last: 0, busy_start: 0, exp_err: 0, exp_q: 2'b01};
        jobs[3] = '{q: 2'b01, gap: 0,  bp: 0, bad_a: 100, drop_b_last: 1, busy_start: 0, exp_err: 1, exp_q: 2'b01};
        jobs[4] = '{q: 2'b01, gap: 0,  bp: 0, bad_a: -1,  drop_b_last: 0, busy_start: 1, exp_err: 0, exp_q: 2'b01};

        rst = 1'b0;
        ctl_start = 1'b0;
        ctl_q = 2'b00;
        s_tvalid = 1'b0;
        s_tdata = '0;
        s_tlast = 1'b0;
        m_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset_outputs_zero");
        rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) run_job(jobs[i]);

        // Abort in the middle of the B stream, then prove the block recovers cleanly.
        ctl_q = 2'b01;
        ctl_start = 1'b1;
        @(posedge clk); #1;
        ctl_start = 1'b0;
        for (int k = 0; k < WORDS; k++) send_word(a_word(k), k == WORDS - 1);
        for (int k = 0; k < 500; k++) send_word(B_WORD, 1'b0);
        s_tvalid = 1'b1;
        s_tdata = B_WORD;
        rst = 1'b0;
        @(posedge clk); #1;
        check_all_zero("midjob_reset_outputs_zero");
        rst = 1'b1;
        s_tvalid = 1'b0;
        repeat (12) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("no_stale_results_after_reset", m_tvalid, 0);
        chk("idle_after_reset", ctl_busy, 0);
        @(posedge clk); #1;
        run_job(jobs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
